// File: rtl/tube_access_sequencer.sv
// Maps host IO cycles in the &FC10-&FC17 window onto timed 6502-style Tube cycles (CS/RnW/PHI2).
// Host is held with WAIT_OUT_B for SETUP+PHI2+hold cycles; read data stays on the host bus until IOREQ_B rises.
module tube_access_sequencer #(
    parameter logic [11:0] BASE_TOP12   = 12'hFC1,
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned PHI2_CYC     = 2,
    parameter int unsigned RECOVERY_CYC = 2
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic [15:0] ADR,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic [7:0]  HOST_DIN,
    output logic [7:0]  HOST_DOUT,
    output logic        HOST_DOUT_EN,
    output logic        WAIT_OUT_B,
    input  logic [7:0]  TUBE_DIN,
    output logic [7:0]  TUBE_DOUT,
    output logic        TUBE_DOUT_EN,
    output logic [2:0]  TUBE_ADR,
    output logic        TUBE_RNW,
    output logic        TUBE_CS_B,
    output logic        TUBE_PHI2,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC) - 4'd1;
    localparam logic [3:0] PHI2_LD  = 4'(PHI2_CYC) - 4'd1;
    localparam logic [3:0] REC_LD   = 4'(RECOVERY_CYC) - 4'd1;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        done_q;
    logic [2:0]  adr_q;
    logic        rnw_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rd_data_q;

    logic        in_window;
    logic        req;
    logic        tube_active;
    logic        launch;
    logic        capture;
    logic        leave_hold;

    assign in_window = (ADR[15:4] == BASE_TOP12) && !ADR[3];
    assign req       = !IOREQ_B && (!RD_B || !WR_B) && in_window;

    // done_q masks req so a long host cycle cannot launch a second Tube access.
    assign WAIT_OUT_B = !(req && !done_q);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        launch     = 1'b0;
        capture    = 1'b0;
        leave_hold = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req && !done_q && (cnt == 4'd0)) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                    launch    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_STROBE;
                    cnt_nxt   = PHI2_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = 4'd0;
                    capture   = rnw_q;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                leave_hold = 1'b1;
                if (RECOVERY_CYC == 0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    state_nxt = ST_RECOVER;
                    cnt_nxt   = REC_LD;
                end
            end
            ST_RECOVER: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            done_q    <= 1'b0;
            adr_q     <= 3'd0;
            rnw_q     <= 1'b1;
            wdata_q   <= 8'd0;
            rd_data_q <= 8'd0;
        end else begin
            if (launch) begin
                adr_q   <= ADR[2:0];
                rnw_q   <= WR_B;
                wdata_q <= HOST_DIN;
            end
            if (capture) begin
                rd_data_q <= TUBE_DIN;
            end
            // Setting wins so an IOREQ_B rise mid-access is only honoured after HOLD.
            if (leave_hold) begin
                done_q <= 1'b1;
            end else if (IOREQ_B) begin
                done_q <= 1'b0;
            end
        end
    end

    // Tube pins decode straight from the state register so reset drops PHI2/CS at once.
    assign tube_active  = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
    assign TUBE_CS_B    = !tube_active;
    assign TUBE_PHI2    = (state == ST_STROBE);
    assign TUBE_RNW     = rnw_q;
    assign TUBE_ADR     = adr_q;
    assign TUBE_DOUT    = wdata_q;
    assign TUBE_DOUT_EN = tube_active && !rnw_q;
    assign HOST_DOUT    = rd_data_q;
    assign HOST_DOUT_EN = done_q && !IOREQ_B && !RD_B && in_window;
    assign BUSY         = (state != ST_IDLE);

endmodule
